writeback_logic_gen: RTL

- Write-side counterpart of the tile fetch logic. Accepts a stream of DATA_WIDTH result words from the systolic array or post-processing units, and generates BRAM write addresses, write enables and write data tile by tile.
- Uses the same per-buffer base-offset map and tile sizing as the fetch side, so anything written here is fetched back at matching addresses.
- Sits between the compute datapath and the port-B (write) side of the shared BRAM.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/writeback_logic_gen_if.sv | 22 ++
 rtl/wb_addr_gen.sv | 34 +++
 rtl/writeback_logic_gen.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Address-map constants shared by the fetch and writeback tile generators,
// so both sides always agree on where each buffer lives.
package fetch_pkg;

    localparam logic [2:0] BUF_W = 3'b000;
    localparam logic [2:0] BUF_B = 3'b001;
    localparam logic [2:0] BUF_I = 3'b010;
    localparam logic [2:0] BUF_Q = 3'b011;
    localparam logic [2:0] BUF_K = 3'b100;
    localparam logic [2:0] BUF_V = 3'b101;

    localparam int BASE_B = 64;
    localparam int BASE_I = 112;

    localparam int TILE_WEIGHTS = 32;
    localparam int TILE_INPUTS  = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_t;

    // Words occupied by one Q/K/V matrix region.
    function automatic int mat_words(input int cols, input int rows,
                                     input int bits, input int dw);
        return cols * rows * bits / dw;
    endfunction

endpackage

// File: rtl/writeback_logic_gen_if.sv
// Result stream in, BRAM port-B write bus out.
interface writeback_logic_gen_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 256
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_we;
    logic [DATA_WIDTH-1:0] bram_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, bram_addr, bram_we, bram_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, bram_addr, bram_we, bram_wdata
    );
endinterface

// File: rtl/wb_addr_gen.sv
// Combinational write address: base(select) + tile_ptr*N + beat index,
// computed at 17 bits and truncated to the BRAM address width.
module wb_addr_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAT_WORDS  = 12288
) (
    input  logic [2:0]            sel,
    input  logic                  tc,
    input  logic [8:0]            tile_ptr,
    input  logic [8:0]            beat_cnt,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [16:0] base;
    logic [16:0] tile_size;
    logic [16:0] sum;

    always_comb begin
        case (sel)
            BUF_B:   base = 17'(BASE_B);
            BUF_I:   base = 17'(BASE_I);
            BUF_K:   base = 17'(MAT_WORDS);
            BUF_V:   base = 17'(2 * MAT_WORDS);
            default: base = '0;
        endcase
        tile_size = tc ? 17'(TILE_WEIGHTS) : 17'(TILE_INPUTS);
        sum = base + 17'(tile_ptr) * tile_size + 17'(beat_cnt);
    end

    assign addr = ADDR_WIDTH'(sum);

endmodule

// File: rtl/writeback_logic_gen.sv
// Tile writeback sequencer: accepts result beats and issues registered
// BRAM writes at the same per-buffer addresses the fetch side reads.
//
// state   | meaning
// IDLE    | waiting for start_write; select/size latched on exit
// WRITING | in_ready high, each accepted beat becomes a write next cycle
// FLUSH   | last write on the BRAM bus, no more beats taken
// DONE    | write_done pulse, tile pointer advances
module writeback_logic_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 256,
    parameter int ORIGINAL_COLUMNS = 768,
    parameter int ORIGINAL_ROWS    = 512,
    parameter int NUM_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_write,
    input  logic                 reset_addr_counter,
    input  logic                 abort,
    input  logic [2:0]           Buffer_Select,
    input  logic                 Tiles_Control,
    writeback_logic_gen_if.slave bus,
    output logic                 write_done,
    output logic                 busy
);

    localparam int MAT_WORDS = mat_words(ORIGINAL_COLUMNS, ORIGINAL_ROWS, NUM_BITS, DATA_WIDTH);

    wb_state_t             state, state_next;
    logic [8:0]            tile_ptr;
    logic [8:0]            beat_cnt;
    logic [2:0]            sel_q;
    logic                  tc_q;
    logic                  accept;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] addr_calc;

    wb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAT_WORDS  (MAT_WORDS)
    ) u_addr_gen (
        .sel      (sel_q),
        .tc       (tc_q),
        .tile_ptr (tile_ptr),
        .beat_cnt (beat_cnt),
        .addr     (addr_calc)
    );

    assign accept    = (state == ST_WRITING) && bus.in_valid;
    assign last_beat = tc_q ? (beat_cnt == 9'(TILE_WEIGHTS - 1))
                            : (beat_cnt == 9'(TILE_INPUTS - 1));

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        write_done   = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_write) state_next = ST_WRITING;
            end
            ST_WRITING: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (abort)                    state_next = ST_IDLE;
                else if (accept && last_beat) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy       = 1'b1;
                state_next = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                write_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            tile_ptr       <= '0;
            beat_cnt       <= '0;
            sel_q          <= '0;
            tc_q           <= 1'b0;
            bus.bram_addr  <= '0;
            bus.bram_we    <= 1'b0;
            bus.bram_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            state       <= state_next;
            bus.bram_we <= accept;
            if (accept) begin
                bus.bram_addr  <= addr_calc;
                bus.bram_wdata <= bus.in_data;
            end
            if (state_next == ST_IDLE) beat_cnt <= '0;
            else if (accept)           beat_cnt <= beat_cnt + 9'd1;
            // a pointer clear outranks the end-of-tile advance
            if (reset_addr_counter)     tile_ptr <= '0;
            else if (state == ST_DONE)  tile_ptr <= tile_ptr + 9'd1;
            if (state == ST_IDLE && start_write) begin
                sel_q <= Buffer_Select;
                tc_q  <= Tiles_Control;
            end
        end
    end

endmodule
